// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - switch/button inputs and operand/result/flag outputs of the sequential ALU core
interface alu_seq_core_if #(
  parameter int WIDTH = 8
);
  logic             btnC;
  logic [WIDTH-1:0] din;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic [3:0]       flags;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output btnC, din, op,
    input  a_val, b_val, y, y_hi, flags, state, busy, done
  );

  modport slave (
    input  btnC, din, op,
    output a_val, b_val, y, y_hi, flags, state, busy, done
  );
endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - button-stepped operand loader with single-cycle ALU ops and shift-add multiply
module alu_seq_core #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 250000
) (
  input  logic           clk,
  input  logic           btnU,
  alu_seq_core_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int               CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]    DB_LAST  = CW'(DB_CYCLES - 1);
  localparam int               MCW      = $clog2(WIDTH);
  localparam logic [MCW-1:0]   MUL_LAST = MCW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [3:0]       OP_MUL   = 4'd8;
  localparam int               MSB      = WIDTH - 1;

  logic          sync1, sync2, db_level, press;
  logic [CW-1:0] db_cnt;

  // Level flips on the DB_CYCLES-th consecutive differing sample; rising flips emit press.
  always_ff @(posedge clk) begin
    if (btnU) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= bus.btnC;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
        press    <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  state_t           state_q, state_d;
  logic             load_a, load_b, write_res;
  logic [WIDTH-1:0] a_q, b_q, y_q, y_hi_q;
  logic [3:0]       op_r, flags_q;
  logic             done_q;
  logic [WIDTH-1:0] m_hi, m_lo, m_hi_n, m_lo_n;
  logic [WIDTH:0]   mul_sum;
  logic [MCW-1:0]   mul_cnt;

  always_ff @(posedge clk) begin
    if (btnU) state_q <= LOAD_A;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_a    = 1'b0;
    load_b    = 1'b0;
    write_res = 1'b0;
    case (state_q)
      LOAD_A: if (press) begin
        load_a  = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        load_b  = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (op_r != OP_MUL || mul_cnt == MUL_LAST) begin
        write_res = 1'b1;
        state_d   = DONE;
      end
      DONE: if (press) begin
        load_a  = 1'b1;
        state_d = LOAD_B;
      end
      default: state_d = LOAD_A;
    endcase
  end

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_r)
      4'd0: begin
        alu_y = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != a_q[MSB]);
      end
      4'd1: begin
        alu_y = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != a_q[MSB]);
      end
      4'd2: alu_y = a_q & b_q;
      4'd3: alu_y = a_q | b_q;
      4'd4: alu_y = a_q ^ b_q;
      4'd5: alu_y = ~a_q;
      4'd6: alu_y = (b_q >= W_VAL) ? '0 : (a_q << b_q);
      4'd7: alu_y = (b_q >= W_VAL) ? '0 : (a_q >> b_q);
      4'd9: alu_y = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
      default: alu_y = '0;
    endcase
  end

  // One right-shift multiply step: add A into the high half when the multiplier LSB is set.
  assign mul_sum = {1'b0, m_hi} + (m_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign m_hi_n  = mul_sum[WIDTH:1];
  assign m_lo_n  = {mul_sum[0], m_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (btnU) begin
      a_q     <= '0;
      b_q     <= '0;
      op_r    <= '0;
      y_q     <= '0;
      y_hi_q  <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      mul_cnt <= '0;
    end else begin
      done_q <= write_res;
      if (load_a) a_q <= bus.din;
      if (load_b) begin
        b_q     <= bus.din;
        op_r    <= bus.op;
        m_hi    <= '0;
        m_lo    <= bus.din;
        mul_cnt <= '0;
      end
      if (state_q == EXEC && op_r == OP_MUL) begin
        m_hi    <= m_hi_n;
        m_lo    <= m_lo_n;
        mul_cnt <= mul_cnt + 1'b1;
      end
      if (write_res) begin
        if (op_r == OP_MUL) begin
          y_q     <= m_lo_n;
          y_hi_q  <= m_hi_n;
          flags_q <= {m_lo_n[MSB], ({m_hi_n, m_lo_n} == '0), |m_hi_n, |m_hi_n};
        end else begin
          y_q     <= alu_y;
          y_hi_q  <= '0;
          flags_q <= {alu_y[MSB], (alu_y == '0), alu_c, alu_v};
        end
      end
    end
  end

  assign bus.a_val = a_q;
  assign bus.b_val = b_q;
  assign bus.y     = y_q;
  assign bus.y_hi  = y_hi_q;
  assign bus.flags = flags_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == EXEC);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - scoreboard bench for alu_seq_core at WIDTH=8, DB_CYCLES=4
module tb_alu_seq_core;
  localparam int W = 8;

  logic clk  = 1'b0;
  logic btnU = 1'b1;

  alu_seq_core_if #(.WIDTH(W)) bus ();

  alu_seq_core #(.WIDTH(W), .DB_CYCLES(4)) dut (
    .clk  (clk),
    .btnU (btnU),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [7:0] y_hi;
    logic [3:0] flags;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, exec_start = 0, done_cnt = 0, busy_cnt = 0, trans_cnt = 0;
  logic [1:0] prev_state = 2'd0;
  logic       prev_done  = 1'b0;

  // Scoreboard side: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.state != prev_state) trans_cnt++;
    if (bus.state == 2'd2 && prev_state != 2'd2) exec_start = cyc;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      total++;
      if (prev_done !== 1'b0) begin bad++; $display("FAIL done_width: prev done=%b required 0", prev_done); end
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL unexpected_done: y=%h with empty scoreboard", bus.y);
      end else begin
        e = sb.pop_front();
        if (bus.y !== e.y) begin bad++; $display("FAIL y: got %h exp %h", bus.y, e.y); end
        total++;
        if (bus.y_hi !== e.y_hi) begin bad++; $display("FAIL y_hi: got %h exp %h", bus.y_hi, e.y_hi); end
        total++;
        if (bus.flags !== e.flags) begin bad++; $display("FAIL flags: got %b exp %b", bus.flags, e.flags); end
        total++;
        if (cyc - exec_start !== e.lat) begin bad++; $display("FAIL latency: got %0d exp %0d", cyc - exec_start, e.lat); end
        total++;
        if (bus.state !== 2'd3) begin bad++; $display("FAIL done_state: got %0d exp 3", bus.state); end
      end
    end
    prev_state = bus.state;
    prev_done  = bus.done;
  end

  function automatic exp_t model(input int a, input int b, input int o);
    exp_t e;
    int r, hi, sa, sbv, s;
    logic c, v;
    r = 0; hi = 0; c = 1'b0; v = 1'b0;
    sa  = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    case (o)
      0: begin r = a + b; c = (r > 255); s = sa + sbv; v = (s > 127) || (s < -128); r = r & 255; end
      1: begin r = (a - b) & 255; c = (a < b); s = sa - sbv; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & 255;
      6: r = (b >= 8) ? 0 : ((a << b) & 255);
      7: r = (b >= 8) ? 0 : (a >> b);
      8: begin s = a * b; r = s & 255; hi = s >> 8; c = (hi != 0); v = c; end
      9: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    e.y     = r[7:0];
    e.y_hi  = hi[7:0];
    e.flags = {r[7], (o == 8) ? (r == 0 && hi == 0) : (r == 0), c, v};
    e.lat   = (o == 8) ? 8 : 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] d, input logic [3:0] o);
    bus.din  = d;
    bus.op   = o;
    bus.btnC = 1'b1;
    repeat (12) step();
    bus.btnC = 1'b0;
    repeat (12) step();
  endtask

  task automatic push_exp(input logic [7:0] y, input logic [7:0] yh, input logic [3:0] f, input int lat);
    exp_t e;
    e.y = y; e.y_hi = yh; e.flags = f; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    btnU = 1'b1;
    repeat (3) step();
    total++;
    if ({bus.a_val, bus.b_val, bus.y, bus.y_hi, bus.flags, bus.busy, bus.done} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h/%h/%h/%h/%b/%b/%b exp all 0",
                      bus.a_val, bus.b_val, bus.y, bus.y_hi, bus.flags, bus.busy, bus.done);
    end
    total++;
    if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d exp 0", bus.state); end
    btnU = 1'b0;
    step();
  endtask

  task automatic test_add();
    int d0;
    d0 = done_cnt;
    press(8'h7F, 4'd0);
    total++;
    if (bus.a_val !== 8'h7F) begin bad++; $display("FAIL add_a_val: got %h exp 7f", bus.a_val); end
    total++;
    if (bus.state !== 2'd1) begin bad++; $display("FAIL add_state_b: got %0d exp 1", bus.state); end
    push_exp(8'h80, 8'h00, 4'b1001, 1);
    press(8'h01, 4'd0);
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL add_done_count: got %0d exp 1", done_cnt - d0); end
    total++;
    if (bus.b_val !== 8'h01) begin bad++; $display("FAIL add_b_val: got %h exp 01", bus.b_val); end
  endtask

  task automatic test_sub();
    press(8'h05, 4'd0);
    push_exp(8'hFE, 8'h00, 4'b1010, 1);
    press(8'h07, 4'd1);
    press(8'h10, 4'd0);
    total++;
    if (bus.a_val !== 8'h10) begin bad++; $display("FAIL chain_a_val: got %h exp 10", bus.a_val); end
    total++;
    if (bus.state !== 2'd1) begin bad++; $display("FAIL chain_state: got %0d exp 1", bus.state); end
    sb.push_back(model(8'h10, 8'h03, 9));
    press(8'h03, 4'd9);
  endtask

  task automatic test_mul();
    int b0, d0;
    press(8'hFF, 4'd0);
    push_exp(8'h01, 8'hFE, 4'b0011, 8);
    b0 = busy_cnt;
    d0 = done_cnt;
    bus.din = 8'hFF; bus.op = 4'd8; bus.btnC = 1'b1;
    for (int i = 0; i < 20 && bus.state != 2'd2; i++) step();
    total++;
    if (bus.state !== 2'd2) begin bad++; $display("FAIL mul_enter_exec: got state %0d exp 2", bus.state); end
    bus.din = 8'h55; bus.op = 4'd0;
    for (int i = 0; i < 20 && bus.state != 2'd3; i++) begin
      bus.btnC = ~bus.btnC;
      step();
    end
    bus.btnC = 1'b0;
    repeat (12) step();
    total++;
    if (busy_cnt - b0 !== 8) begin bad++; $display("FAIL mul_busy_cycles: got %0d exp 8", busy_cnt - b0); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL mul_done_count: got %0d exp 1", done_cnt - d0); end
    total++;
    if ({bus.a_val, bus.b_val, bus.state} !== {8'hFF, 8'hFF, 2'd3}) begin
      bad++; $display("FAIL mul_hold: got a=%h b=%h st=%0d exp ff ff 3", bus.a_val, bus.b_val, bus.state);
    end
  endtask

  task automatic test_bounce();
    int tc0;
    tc0 = trans_cnt;
    bus.din = 8'h33;
    bus.btnC = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.btnC = ~bus.btnC;
      repeat (2) step();
    end
    bus.btnC = 1'b1;
    repeat (12) step();
    bus.btnC = 1'b0;
    repeat (12) step();
    total++;
    if (trans_cnt - tc0 !== 1) begin bad++; $display("FAIL bounce_advances: got %0d exp 1", trans_cnt - tc0); end
    total++;
    if (bus.a_val !== 8'h33 || bus.state !== 2'd1) begin
      bad++; $display("FAIL bounce_load: got a=%h st=%0d exp 33 1", bus.a_val, bus.state);
    end
    tc0 = trans_cnt;
    bus.btnC = 1'b1;
    repeat (3) step();
    bus.btnC = 1'b0;
    repeat (12) step();
    total++;
    if (trans_cnt !== tc0 || bus.state !== 2'd1) begin
      bad++; $display("FAIL glitch: got %0d advances st=%0d exp 0 advances st=1", trans_cnt - tc0, bus.state);
    end
  endtask

  task automatic test_shift();
    sb.push_back(model(8'h33, 8'h01, 7));
    press(8'h01, 4'd7);
    press(8'h81, 4'd0);
    push_exp(8'h02, 8'h00, 4'b0000, 1);
    press(8'h01, 4'd6);
    press(8'h81, 4'd0);
    push_exp(8'h00, 8'h00, 4'b0100, 1);
    press(8'h08, 4'd6);
    press(8'h05, 4'd0);
    push_exp(8'h00, 8'h00, 4'b0100, 1);
    press(8'h03, 4'd12);
  endtask

  task automatic test_reset_mid_mul();
    int d0;
    press(8'hFF, 4'd0);
    d0 = done_cnt;
    bus.din = 8'hFF; bus.op = 4'd8; bus.btnC = 1'b1;
    for (int i = 0; i < 20 && bus.state != 2'd2; i++) step();
    total++;
    if (bus.state !== 2'd2) begin bad++; $display("FAIL rst_mul_exec: got state %0d exp 2", bus.state); end
    repeat (3) step();
    btnU = 1'b1;
    bus.btnC = 1'b0;
    step();
    total++;
    if ({bus.a_val, bus.b_val, bus.y, bus.y_hi, bus.flags, bus.state, bus.busy, bus.done} !== '0) begin
      bad++; $display("FAIL rst_mul_outputs: got a=%h b=%h y=%h hi=%h f=%b st=%0d busy=%b done=%b exp all 0",
                      bus.a_val, bus.b_val, bus.y, bus.y_hi, bus.flags, bus.state, bus.busy, bus.done);
    end
    btnU = 1'b0;
    repeat (12) step();
    total++;
    if (done_cnt !== d0) begin bad++; $display("FAIL rst_mul_no_done: got %0d dones exp 0", done_cnt - d0); end
    press(8'h03, 4'd0);
    sb.push_back(model(3, 4, 0));
    press(8'h04, 4'd0);
    total++;
    if (bus.y !== 8'h07 || bus.state !== 2'd3) begin
      bad++; $display("FAIL rst_mul_recover: got y=%h st=%0d exp 07 3", bus.y, bus.state);
    end
  endtask

  task automatic test_back_to_back();
    int ops[8] = '{0, 1, 8, 6, 7, 9, 4, 13};
    int a, b, d0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 255);
      b = (ops[i] == 6 || ops[i] == 7) ? $urandom_range(0, 9) : $urandom_range(0, 255);
      press(a[7:0], 4'd0);
      sb.push_back(model(a, b, ops[i]));
      press(b[7:0], ops[i][3:0]);
    end
    total++;
    if (done_cnt - d0 !== 8) begin bad++; $display("FAIL b2b_done_count: got %0d exp 8", done_cnt - d0); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left exp 0", sb.size()); end
  endtask

  initial begin
    bus.btnC = 1'b0;
    bus.din  = '0;
    bus.op   = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_bounce();
    test_shift();
    test_reset_mid_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised sequential ALU core, the successor to the fixed 8-bit switch/button ALU top. Operand width is generic. Button presses step an operand-load FSM: load A, load B, execute. Multiply is a multi-cycle shift-add. The core drives operand, result and flag outputs for the board LED and 7-segment wrappers.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
DB_CYCLES, 250000, consecutive stable synchronised samples required to accept a btnC level change (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
btnU  input  1  reset, synchronous, active-high
btnC  input  1  raw step button (asynchronous, bouncy)
din  input  WIDTH  operand data from switches
op  input  4  operation select, sampled on the B-load press
a_val  output  WIDTH  stored operand A
b_val  output  WIDTH  stored operand B
y  output  WIDTH  result (low half for MUL)
y_hi  output  WIDTH  high half of MUL product; 0 for other ops
flags  output  4  {N,Z,C,V}, updated when a result completes
state  output  2  FSM state: 0 LOAD_A, 1 LOAD_B, 2 EXEC, 3 DONE
busy  output  1  high while in EXEC
done  output  1  one-cycle pulse when a result is written

Behaviour:
- Reset: one clock and reset, clk and btnU. Reset is synchronous and active-high. It clears a_val, b_val, y, y_hi, flags, done, busy, the MUL counter and the debounce state to 0, and sets state to LOAD_A. Reset aborts any MUL in progress.
- btnC conditioning: 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive samples that differ from the current level.
  - press = one-cycle pulse on the debounced rising edge.
- LOAD_A: on press, a_val<=din and go to LOAD_B.
- LOAD_B: on press, b_val<=din, op_r<=op, and go to EXEC.
- EXEC: presses are ignored.
  - Single-cycle ops: result is written on the first EXEC cycle, then go to DONE.
  - If the B-load press is at cycle t, y, flags and done are valid at t+2.
- MUL (op 8): shift-add over WIDTH cycles in EXEC. The 2*WIDTH product lands in {y_hi,y}. Result, done and DONE state occur at t+1+WIDTH.
- DONE: y, y_hi and flags hold. On press, a_val<=din and go to LOAD_B (chained entry).
- y, y_hi and flags change only on result write or reset.
- Ops, all unsigned unless stated:
  - 0 ADD: y=A+B. C=carry out. V=signed overflow.
  - 1 SUB: y=A-B. C=borrow (A<B). V=signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise. C=V=0.
  - 5 NOT: y=~A. C=V=0.
  - 6 SHL, 7 SHR: A shifted logically by B. If B>=WIDTH, y=0. C=V=0.
  - 8 MUL: {y_hi,y}=A*B. C=V=(y_hi!=0). Z=(full product==0).
  - 9 LTU: y=(A<B)?1:0. C=V=0.
  - 10-15 undefined: y=0, y_hi=0, flags={0,1,0,0}.
- Flags: N=y[WIDTH-1]. Z=(y==0), except for MUL. y_hi is cleared on every non-MUL result.
- Simultaneous reset and press: reset wins.
- A press aligned with the EXEC-to-DONE transition is ignored.

Test Plan:
- WIDTH=8, DB_CYCLES=4: reset, then press with din=0x7F, press with din=0x01, op=0 -> at t+2: y=0x80, flags N=1 Z=0 C=0 V=1, done pulses once, state=3.
- SUB with A=0x05, B=0x07 -> y=0xFE, C=1, N=1, V=0. Then press with din=0x10 in DONE -> a_val=0x10, state=1.
- MUL with A=0xFF, B=0xFF -> busy high for 8 cycles. At t+9: {y_hi,y}=0xFE01, C=V=1. Extra presses during EXEC have no effect.
- Bounce: btnC toggles every 2 cycles for 20 cycles, then holds high -> exactly one press, one state advance. A 3-cycle glitch -> no press.
- SHL with A=0x81, B=1 -> y=0x02. SHL with B=8 -> y=0, Z=1. Op 12 -> y=0, flags=0100.
- btnU asserted on MUL cycle 4 -> next cycle all outputs 0, state=0. A new load sequence then works normally.
